// File: rtl/bomberman_pkg.sv
// Shared bomberman definitions: bomb slot defaults, slot-state encoding and
// the placement tile-snapping helper.
package bomberman_pkg;

  localparam int TILE_DEFAULT       = 16;
  localparam int MAX_BOMBS_DEFAULT  = 3;
  localparam int FUSE_TICKS_DEFAULT = 3;

  typedef enum logic [1:0] {
    SLOT_FREE    = 2'd0,
    SLOT_ARMED   = 2'd1,
    SLOT_PENDING = 2'd2
  } slot_state_e;

  // Round a sprite corner to the nearest tile origin; 10-bit wrap is ignored.
  function automatic logic [9:0] snap_to_tile(input logic [9:0] p, input int tile);
    return (p + 10'(tile / 2)) & ~10'(tile - 1);
  endfunction

endpackage

// File: rtl/bomb_slot.sv
// One bomb slot: lifecycle state, fuse counter, stored tile and the
// pixel-inside-sprite compare used by the renderer.
module bomb_slot
  import bomberman_pkg::*;
#(
  parameter int TILE       = TILE_DEFAULT,
  parameter int FUSE_TICKS = FUSE_TICKS_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       arm_i,
  input  logic       tick_i,
  input  logic       issue_i,
  input  logic [9:0] tile_x_i,
  input  logic [9:0] tile_y_i,
  input  logic [9:0] v_x_i,
  input  logic [9:0] v_y_i,
  output logic       busy_o,
  output logic       pending_o,
  output logic [9:0] tile_x_o,
  output logic [9:0] tile_y_o,
  output logic       hit_o,
  output logic [3:0] col_o,
  output logic [3:0] row_o
);

  localparam int FW = (FUSE_TICKS > 1) ? $clog2(FUSE_TICKS + 1) : 1;

  slot_state_e   state_q, state_d;
  logic [FW-1:0] fuse_q, fuse_d;
  logic [9:0]    tx_q, tx_d, ty_q, ty_d;
  logic [10:0]   dx, dy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SLOT_FREE;
      fuse_q  <= '0;
      tx_q    <= 10'd0;
      ty_q    <= 10'd0;
    end else begin
      state_q <= state_d;
      fuse_q  <= fuse_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
    end
  end

  // Arming only happens from FREE, so a tick in the arming cycle is ignored.
  always_comb begin
    state_d = state_q;
    fuse_d  = fuse_q;
    tx_d    = tx_q;
    ty_d    = ty_q;
    case (state_q)
      SLOT_FREE: begin
        if (arm_i) begin
          state_d = SLOT_ARMED;
          fuse_d  = FW'(FUSE_TICKS);
          tx_d    = tile_x_i;
          ty_d    = tile_y_i;
        end else begin
          state_d = SLOT_FREE;
        end
      end
      SLOT_ARMED: begin
        if (tick_i) begin
          fuse_d = fuse_q - FW'(1);
          if (fuse_q == FW'(1)) begin
            state_d = SLOT_PENDING;
          end else begin
            state_d = SLOT_ARMED;
          end
        end else begin
          state_d = SLOT_ARMED;
        end
      end
      SLOT_PENDING: begin
        if (issue_i) begin
          state_d = SLOT_FREE;
        end else begin
          state_d = SLOT_PENDING;
        end
      end
      default: state_d = SLOT_FREE;
    endcase
  end

  // A pixel left of / above the tile borrows into bit 10 and fails the compare.
  assign dx        = {1'b0, v_x_i} - {1'b0, tx_q};
  assign dy        = {1'b0, v_y_i} - {1'b0, ty_q};
  assign hit_o     = (state_q == SLOT_ARMED) && (dx < 11'(TILE)) && (dy < 11'(TILE));
  assign col_o     = dx[3:0];
  assign row_o     = dy[3:0];
  assign busy_o    = (state_q != SLOT_FREE);
  assign pending_o = (state_q == SLOT_PENDING);
  assign tile_x_o  = tx_q;
  assign tile_y_o  = ty_q;

endmodule

// File: rtl/bomb_fuse_controller.sv
// Bomb placement and detonation sequencing: C edge detect, slot allocation,
// one-per-cycle detonation issue and registered sprite-hit outputs.
module bomb_fuse_controller
  import bomberman_pkg::*;
#(
  parameter int MAX_BOMBS  = MAX_BOMBS_DEFAULT,
  parameter int FUSE_TICKS = FUSE_TICKS_DEFAULT,
  parameter int TILE       = TILE_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fuse_tick,
  input  logic       C,
  input  logic [9:0] b_x,
  input  logic [9:0] b_y,
  input  logic [9:0] v_x,
  input  logic [9:0] v_y,
  output logic [9:0] exploding_bomb_x,
  output logic [9:0] exploding_bomb_y,
  output logic       explosion_write_enable,
  output logic       bomb_on,
  output logic [3:0] bomb_col,
  output logic [3:0] bomb_row,
  output logic [1:0] bombs_active
);

  logic [MAX_BOMBS-1:0] busy, pending, hit, arm, issue;
  logic [9:0]           slot_x [MAX_BOMBS];
  logic [9:0]           slot_y [MAX_BOMBS];
  logic [3:0]           slot_col [MAX_BOMBS];
  logic [3:0]           slot_row [MAX_BOMBS];

  logic       c_prev_q;
  logic       we_q, we_d;
  logic [9:0] ex_x_q, ex_x_d, ex_y_q, ex_y_d;
  logic       on_q, on_d;
  logic [3:0] col_q, col_d, row_q, row_d;
  logic [1:0] cnt_q, cnt_d;
  logic [9:0] place_x, place_y;
  logic       place_edge, dup, found_free, found_pend, found_hit;

  for (genvar g = 0; g < MAX_BOMBS; g++) begin : g_slot
    bomb_slot #(.TILE(TILE), .FUSE_TICKS(FUSE_TICKS)) u_slot (
      .clk      (clk),
      .reset    (reset),
      .arm_i    (arm[g]),
      .tick_i   (fuse_tick),
      .issue_i  (issue[g]),
      .tile_x_i (place_x),
      .tile_y_i (place_y),
      .v_x_i    (v_x),
      .v_y_i    (v_y),
      .busy_o   (busy[g]),
      .pending_o(pending[g]),
      .tile_x_o (slot_x[g]),
      .tile_y_o (slot_y[g]),
      .hit_o    (hit[g]),
      .col_o    (slot_col[g]),
      .row_o    (slot_row[g])
    );
  end

  assign place_x    = snap_to_tile(b_x, TILE);
  assign place_y    = snap_to_tile(b_y, TILE);
  assign place_edge = C & ~c_prev_q;

  // A slot being issued this cycle is still PENDING, hence not yet free.
  always_comb begin
    dup        = 1'b0;
    found_free = 1'b0;
    found_pend = 1'b0;
    found_hit  = 1'b0;
    arm        = '0;
    issue      = '0;
    we_d       = 1'b0;
    ex_x_d     = ex_x_q;
    ex_y_d     = ex_y_q;
    on_d       = 1'b0;
    col_d      = 4'd0;
    row_d      = 4'd0;
    cnt_d      = 2'd0;
    for (int i = 0; i < MAX_BOMBS; i++) begin
      if (busy[i] && (slot_x[i] == place_x) && (slot_y[i] == place_y)) begin
        dup = 1'b1;
      end else begin
        dup = dup;
      end
      if (!found_free && !busy[i] && place_edge) begin
        found_free = 1'b1;
        arm[i]     = 1'b1;
      end else begin
        found_free = found_free;
      end
      if (!found_pend && pending[i]) begin
        found_pend = 1'b1;
        issue[i]   = 1'b1;
        we_d       = 1'b1;
        ex_x_d     = slot_x[i];
        ex_y_d     = slot_y[i];
      end else begin
        found_pend = found_pend;
      end
      if (!found_hit && hit[i]) begin
        found_hit = 1'b1;
        on_d      = 1'b1;
        col_d     = slot_col[i];
        row_d     = slot_row[i];
      end else begin
        found_hit = found_hit;
      end
      cnt_d = cnt_d + {1'b0, busy[i]};
    end
    if (dup) begin
      arm = '0;
    end else begin
      arm = arm;
    end
  end

  // Edge history resets high so a button held through reset places nothing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_prev_q <= 1'b1;
      we_q     <= 1'b0;
      ex_x_q   <= 10'd0;
      ex_y_q   <= 10'd0;
      on_q     <= 1'b0;
      col_q    <= 4'd0;
      row_q    <= 4'd0;
      cnt_q    <= 2'd0;
    end else begin
      c_prev_q <= C;
      we_q     <= we_d;
      ex_x_q   <= ex_x_d;
      ex_y_q   <= ex_y_d;
      on_q     <= on_d;
      col_q    <= col_d;
      row_q    <= row_d;
      cnt_q    <= cnt_d;
    end
  end

  assign exploding_bomb_x       = ex_x_q;
  assign exploding_bomb_y       = ex_y_q;
  assign explosion_write_enable = we_q;
  assign bomb_on                = on_q;
  assign bomb_col               = col_q;
  assign bomb_row               = row_q;
  assign bombs_active           = cnt_q;

endmodule

// File: tb/tb_bomb_fuse_controller.sv
// Directed bench for bomb_fuse_controller: placement, fuse expiry,
// rejection rules, sprite hit outputs and reset behaviour.
module tb_bomb_fuse_controller;

  logic       clk = 1'b0;
  logic       reset, fuse_tick, C;
  logic [9:0] b_x, b_y, v_x, v_y;
  logic [9:0] exploding_bomb_x, exploding_bomb_y;
  logic       explosion_write_enable, bomb_on;
  logic [3:0] bomb_col, bomb_row;
  logic [1:0] bombs_active;

  int passed = 0;
  int total  = 0;
  int we_seen;

  bomb_fuse_controller dut (
    .clk                   (clk),
    .reset                 (reset),
    .fuse_tick             (fuse_tick),
    .C                     (C),
    .b_x                   (b_x),
    .b_y                   (b_y),
    .v_x                   (v_x),
    .v_y                   (v_y),
    .exploding_bomb_x      (exploding_bomb_x),
    .exploding_bomb_y      (exploding_bomb_y),
    .explosion_write_enable(explosion_write_enable),
    .bomb_on               (bomb_on),
    .bomb_col              (bomb_col),
    .bomb_row              (bomb_row),
    .bombs_active          (bombs_active)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    fuse_tick = 1'b1;
    cyc();
    fuse_tick = 1'b0;
  endtask

  task automatic place(input logic [9:0] x, input logic [9:0] y);
    b_x = x;
    b_y = y;
    C   = 1'b1;
    cyc();
    C   = 1'b0;
    cyc();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic check_out(input string tag, input logic we, input logic [9:0] ex, input logic [9:0] ey,
                           input logic [1:0] cnt);
    check({tag, "_we"}, 32'(explosion_write_enable), 32'(we));
    check({tag, "_ex"}, 32'(exploding_bomb_x), 32'(ex));
    check({tag, "_ey"}, 32'(exploding_bomb_y), 32'(ey));
    check({tag, "_cnt"}, 32'(bombs_active), 32'(cnt));
  endtask

  task automatic check_pix(input string tag, input logic on, input logic [3:0] col, input logic [3:0] row);
    check({tag, "_on"}, 32'(bomb_on), 32'(on));
    check({tag, "_col"}, 32'(bomb_col), 32'(col));
    check({tag, "_row"}, 32'(bomb_row), 32'(row));
  endtask

  initial begin
    reset = 1'b1; fuse_tick = 1'b0; C = 1'b0;
    b_x = 10'd0; b_y = 10'd0; v_x = 10'd0; v_y = 10'd0;
    cyc(); cyc();
    check_out("rst", 1'b0, 10'd0, 10'd0, 2'd0);
    check_pix("rst", 1'b0, 4'd0, 4'd0);
    reset = 1'b0;
    cyc();

    // Single bomb: (100,50) snaps to (96,48), detonates after three ticks
    place(10'd100, 10'd50);
    check_out("arm1", 1'b0, 10'd0, 10'd0, 2'd1);
    tick(); tick(); tick();
    check_out("pre_det", 1'b0, 10'd0, 10'd0, 2'd1);
    cyc();
    check_out("det1", 1'b1, 10'd96, 10'd48, 2'd1);
    cyc();
    check_out("det1_after", 1'b0, 10'd96, 10'd48, 2'd0);

    // Sprite hit on the bomb at (96,48)
    place(10'd100, 10'd50);
    v_x = 10'd100; v_y = 10'd50; cyc();
    check_pix("pix_in", 1'b1, 4'd4, 4'd2);
    v_x = 10'd111; v_y = 10'd63; cyc();
    check_pix("pix_corner", 1'b1, 4'd15, 4'd15);
    v_x = 10'd112; v_y = 10'd48; cyc();
    check_pix("pix_right", 1'b0, 4'd0, 4'd0);
    v_x = 10'd95; v_y = 10'd48; cyc();
    check_pix("pix_left", 1'b0, 4'd0, 4'd0);

    // Fill all three slots, fourth placement rejected
    place(10'd200, 10'd50);
    place(10'd300, 10'd50);
    check_out("full", 1'b0, 10'd96, 10'd48, 2'd3);
    place(10'd400, 10'd50);
    cyc();
    check_out("reject4", 1'b0, 10'd96, 10'd48, 2'd3);

    // All three expire on the same tick: issued on consecutive cycles by index
    tick(); tick(); tick();
    cyc();
    check_out("multi0", 1'b1, 10'd96, 10'd48, 2'd3);
    cyc();
    check_out("multi1", 1'b1, 10'd208, 10'd48, 2'd2);
    cyc();
    check_out("multi2", 1'b1, 10'd304, 10'd48, 2'd1);
    cyc();
    check_out("multi_end", 1'b0, 10'd304, 10'd48, 2'd0);

    // Arming on a tick cycle does not consume a fuse tick
    b_x = 10'd20; b_y = 10'd20; C = 1'b1; fuse_tick = 1'b1;
    cyc();
    C = 1'b0; fuse_tick = 1'b0;
    tick(); tick(); cyc();
    check_out("armtick_wait", 1'b0, 10'd304, 10'd48, 2'd1);
    tick(); cyc();
    check_out("armtick_det", 1'b1, 10'd16, 10'd16, 2'd1);
    cyc();

    // C held for 100 clocks places once; re-press on same tile rejected
    b_x = 10'd500; b_y = 10'd100; C = 1'b1;
    repeat (100) cyc();
    C = 1'b0; cyc();
    check_out("hold", 1'b0, 10'd16, 10'd16, 2'd1);
    place(10'd497, 10'd97);
    cyc();
    check_out("dup_tile", 1'b0, 10'd16, 10'd16, 2'd1);
    tick(); tick(); tick(); cyc();
    check_out("hold_det", 1'b1, 10'd496, 10'd96, 2'd1);
    cyc();
    check_out("hold_end", 1'b0, 10'd496, 10'd96, 2'd0);

    // Reset mid-fuse with C held: bomb dropped, nothing placed afterwards
    place(10'd100, 10'd50);
    tick(); tick();
    C = 1'b1; reset = 1'b1; #1;
    check_out("rst_mid", 1'b0, 10'd0, 10'd0, 2'd0);
    check_pix("rst_mid", 1'b0, 4'd0, 4'd0);
    cyc(); cyc();
    reset = 1'b0;
    v_x = 10'd100; v_y = 10'd50;
    we_seen = 0;
    for (int i = 0; i < 12; i++) begin
      fuse_tick = i[0];
      cyc();
      if (explosion_write_enable) we_seen++;
    end
    fuse_tick = 1'b0;
    check("rst_no_pulse", 32'(we_seen), 32'd0);
    check_out("rst_after", 1'b0, 10'd0, 10'd0, 2'd0);
    check_pix("rst_after", 1'b0, 4'd0, 4'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bomb_fuse_controller.md
BOMB_FUSE_CONTROLLER -- requirements
Module: bomb_fuse_controller

Interface
REQ-001 SHALL have parameter MAX_BOMBS, default 3, number of concurrent bomb slots.
REQ-002 SHALL have parameter FUSE_TICKS, default 3, fuse_tick pulses from placement to detonation.
REQ-003 SHALL have parameter TILE, default 16, bomb/tile edge in pixels (power of two).
REQ-004 clk  input  1  system clock.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 fuse_tick  input  1  one-clk pulse from clock divider; advances fuses.
REQ-007 C  input  1  debounced place-bomb button, level.
REQ-008 b_x, b_y  input  10 each  bomberman top-left pixel.
REQ-009 v_x, v_y  input  10 each  current VGA pixel.
REQ-010 exploding_bomb_x, exploding_bomb_y  output  10 each  tile of most recent detonation, held.
REQ-011 explosion_write_enable  output  1  one-clk pulse per detonation.
REQ-012 bomb_on  output  1  current pixel inside an armed bomb sprite.
REQ-013 bomb_col, bomb_row  output  4 each  pixel offset within that sprite, for bomb ROM.
REQ-014 bombs_active  output  2  count of armed slots.

Function
REQ-015 SHALL detect rising edge of C (C high, previous-cycle C low); held C places one bomb only.
REQ-016 Placement tile SHALL be ((b_x+TILE/2) & ~(TILE-1), (b_y+TILE/2) & ~(TILE-1)), 10-bit wrap ignored.
REQ-017 On edge, SHALL arm lowest-index free slot: store tile, fuse=FUSE_TICKS, state ARMED.
REQ-018 Placement SHALL be rejected silently if no slot free or an ARMED/PENDING slot holds same tile.
REQ-019 Slot states: FREE -> ARMED (placement) -> PENDING (fuse reaches 0) -> FREE (event issued).
REQ-020 Each fuse_tick SHALL decrement every ARMED fuse; fuse 1->0 SHALL move slot to PENDING same edge.
REQ-021 Slot armed in the same cycle as fuse_tick SHALL NOT be decremented that cycle.
REQ-022 Each clk, lowest-index PENDING slot SHALL issue: explosion_write_enable=1 next cycle, exploding_bomb_x/y=its tile, slot -> FREE.
REQ-023 Multiple PENDING slots SHALL issue on consecutive cycles, one per cycle, by index.
REQ-024 exploding_bomb_x/y SHALL hold value until next detonation.
REQ-025 Slot freed in a cycle SHALL NOT be reusable by placement in that same cycle.
REQ-026 bombs_active SHALL count ARMED+PENDING slots, registered.
REQ-027 bomb_on, bomb_col, bomb_row SHALL be registered (1-clk latency) from v_x/v_y vs ARMED slots; lowest index wins on overlap; col/row=v-tile low 4 bits; 0 when bomb_on=0.

Reset
REQ-028 Reset SHALL free all slots, clear fuses, edge detector history=1 (no spurious placement if C held through reset).
REQ-029 All outputs SHALL be 0 during and immediately after reset.
REQ-030 Reset mid-fuse or mid-PENDING SHALL drop the bomb with no write_enable pulse.

Structure
REQ-031 TILE, MAX_BOMBS, FUSE_TICKS defaults and slot-state encoding SHALL live in shared package bomberman_pkg.
REQ-032 One sub-module bomb_slot (fuse counter, state, tile regs, pixel-hit compare) SHALL be instantiated MAX_BOMBS times; arbitration and edge detect in top.

Verification
REQ-033 b=(100,50), C edge, 3 fuse_ticks -> write_enable one pulse, exploding=(96,48), bombs_active 1->0.
REQ-034 Three placements at distinct tiles, fourth C edge -> rejected, bombs_active stays 3.
REQ-035 Two bombs armed same cycle window, expire on same tick -> pulses on consecutive clks, slot0 tile first, then slot1.
REQ-036 C held high 100 clks -> one bomb; second edge at same tile -> rejected.
REQ-037 Bomb at (96,48), v=(100,50) -> next clk bomb_on=1, col=4, row=2; v=(112,48) -> bomb_on=0.
REQ-038 Reset asserted after 2 ticks of an armed bomb -> no pulse ever, all outputs 0, C held through reset places nothing.
